manager_axi: RTL

Simplified AXI initiator that drives the `example_iface` channel set (AW/W/B/AR/R, no strobes or response codes) toward a subordinate in the axi_interconnect example.

- It accepts single read or write commands from a local command port.
- It runs the address/data/response handshakes and returns one response per command on a local response port.
- A per-transaction timeout counter aborts transactions the subordinate never completes and reports them as errors.

---
 rtl/manager_axi.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/manager_axi.sv
// manager_axi: single-outstanding AXI-style initiator for the example_iface
// channel set (AW/W/B/AR/R, no strobes or response codes).
//
// Ports:
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   cmd_valid/cmd_ready    local command handshake; cmd_ready is high in IDLE
//   cmd_write/addr/wdata   command contents, latched on acceptance
//   rsp_valid              one-cycle completion pulse, no backpressure
//   rsp_write/error/rdata  completion info, held until the next response
//   example_iface*         AW/W/B/AR/R channels toward the subordinate
//
// State table:
//   IDLE         | waiting for a command, cmd_ready high
//   WR_ADDR_DATA | AW and W offered independently until both handshake
//   WR_RESP      | BREADY high, waiting for BVALID
//   RD_ADDR      | ARVALID high, waiting for ARREADY
//   RD_DATA      | RREADY high, waiting for RVALID
module manager_axi #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic                  rsp_error,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] example_ifaceAWADDR,
  output logic                  example_ifaceAWVALID,
  input  logic                  example_ifaceAWREADY,
  output logic [DATA_WIDTH-1:0] example_ifaceWDATA,
  output logic                  example_ifaceWVALID,
  input  logic                  example_ifaceWREADY,
  input  logic                  example_ifaceBVALID,
  output logic                  example_ifaceBREADY,
  output logic [ADDR_WIDTH-1:0] example_ifaceARADDR,
  output logic                  example_ifaceARVALID,
  input  logic                  example_ifaceARREADY,
  input  logic [DATA_WIDTH-1:0] example_ifaceRDATA,
  input  logic                  example_ifaceRVALID,
  output logic                  example_ifaceRREADY
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  // Counter reads k-1 in the k-th busy cycle, so this value marks the last one.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  aw_done, aw_done_nxt, w_done, w_done_nxt;
  logic                  wr_flag, wr_flag_nxt;
  logic [ADDR_WIDTH-1:0] aw_addr, aw_addr_nxt, ar_addr, ar_addr_nxt;
  logic [DATA_WIDTH-1:0] w_data, w_data_nxt;
  logic                  aw_valid, aw_valid_nxt, w_valid, w_valid_nxt;
  logic                  ar_valid, ar_valid_nxt, b_ready, b_ready_nxt, r_ready, r_ready_nxt;
  logic                  rsp_valid_nxt, rsp_write_nxt, rsp_error_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_nxt;
  logic                  aw_hs, w_hs, expire, abort;

  assign aw_hs  = aw_valid && example_ifaceAWREADY;
  assign w_hs   = w_valid && example_ifaceWREADY;
  assign expire = (TIMEOUT_CYCLES > 0) && (state != IDLE) && (cnt == CNT_LAST);

  assign cmd_ready            = (state == IDLE);
  assign example_ifaceAWADDR  = aw_addr;
  assign example_ifaceAWVALID = aw_valid;
  assign example_ifaceWDATA   = w_data;
  assign example_ifaceWVALID  = w_valid;
  assign example_ifaceBREADY  = b_ready;
  assign example_ifaceARADDR  = ar_addr;
  assign example_ifaceARVALID = ar_valid;
  assign example_ifaceRREADY  = r_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      wr_flag   <= 1'b0;
      aw_addr   <= '0;
      ar_addr   <= '0;
      w_data    <= '0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      ar_valid  <= 1'b0;
      b_ready   <= 1'b0;
      r_ready   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      aw_done   <= aw_done_nxt;
      w_done    <= w_done_nxt;
      wr_flag   <= wr_flag_nxt;
      aw_addr   <= aw_addr_nxt;
      ar_addr   <= ar_addr_nxt;
      w_data    <= w_data_nxt;
      aw_valid  <= aw_valid_nxt;
      w_valid   <= w_valid_nxt;
      ar_valid  <= ar_valid_nxt;
      b_ready   <= b_ready_nxt;
      r_ready   <= r_ready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_write <= rsp_write_nxt;
      rsp_error <= rsp_error_nxt;
      rsp_rdata <= rsp_rdata_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    aw_done_nxt   = aw_done;
    w_done_nxt    = w_done;
    wr_flag_nxt   = wr_flag;
    aw_addr_nxt   = aw_addr;
    ar_addr_nxt   = ar_addr;
    w_data_nxt    = w_data;
    aw_valid_nxt  = aw_valid;
    w_valid_nxt   = w_valid;
    ar_valid_nxt  = ar_valid;
    b_ready_nxt   = b_ready;
    r_ready_nxt   = r_ready;
    rsp_valid_nxt = 1'b0;
    rsp_write_nxt = rsp_write;
    rsp_error_nxt = rsp_error;
    rsp_rdata_nxt = rsp_rdata;
    abort         = 1'b0;

    if ((state != IDLE) && (cnt != CNT_MAX)) cnt_nxt = cnt + 1'b1;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          wr_flag_nxt = cmd_write;
          cnt_nxt     = '0;
          aw_done_nxt = 1'b0;
          w_done_nxt  = 1'b0;
          if (cmd_write) begin
            aw_addr_nxt  = cmd_addr;
            w_data_nxt   = cmd_wdata;
            aw_valid_nxt = 1'b1;
            w_valid_nxt  = 1'b1;
            state_nxt    = WR_ADDR_DATA;
          end else begin
            ar_addr_nxt  = cmd_addr;
            ar_valid_nxt = 1'b1;
            state_nxt    = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        // Address-phase handshakes are not completions, so expiry wins here.
        if (expire) begin
          abort = 1'b1;
        end else begin
          if (aw_hs) begin
            aw_done_nxt  = 1'b1;
            aw_valid_nxt = 1'b0;
          end
          if (w_hs) begin
            w_done_nxt  = 1'b1;
            w_valid_nxt = 1'b0;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            b_ready_nxt = 1'b1;
            state_nxt   = WR_RESP;
          end
        end
      end
      WR_RESP: begin
        if (b_ready && example_ifaceBVALID) begin
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b1;
          rsp_error_nxt = 1'b0;
          rsp_rdata_nxt = '0;
          b_ready_nxt   = 1'b0;
          state_nxt     = IDLE;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      RD_ADDR: begin
        if (expire) begin
          abort = 1'b1;
        end else if (example_ifaceARREADY) begin
          ar_valid_nxt = 1'b0;
          r_ready_nxt  = 1'b1;
          state_nxt    = RD_DATA;
        end
      end
      RD_DATA: begin
        if (r_ready && example_ifaceRVALID) begin
          rsp_valid_nxt = 1'b1;
          rsp_write_nxt = 1'b0;
          rsp_error_nxt = 1'b0;
          rsp_rdata_nxt = example_ifaceRDATA;
          r_ready_nxt   = 1'b0;
          state_nxt     = IDLE;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (abort) begin
      aw_valid_nxt  = 1'b0;
      w_valid_nxt   = 1'b0;
      ar_valid_nxt  = 1'b0;
      b_ready_nxt   = 1'b0;
      r_ready_nxt   = 1'b0;
      rsp_valid_nxt = 1'b1;
      rsp_error_nxt = 1'b1;
      rsp_write_nxt = wr_flag;
      rsp_rdata_nxt = '0;
      state_nxt     = IDLE;
    end
  end

endmodule
